// File: rtl/fp_ctrl_pkg.sv
// rtl/fp_ctrl_pkg.sv - shared types and helpers for the floating-point adder control path
//
// Purpose: state encoding of the adder sequencer and the alignment shift clamp.
// Contents:
//   SeqState     sequencer state enumeration
//   clamp_shift  saturate a shift request at a limit instead of wrapping

package fp_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ALIGN_EQ,
    ALIGN_GT,
    ALIGN_LT,
    SR,
    SL,
    NOSHIFT,
    ROUND,
    SPECIAL,
    RESULT
  } SeqState;

  // Exponent differences wider than the mantissa+carry window would otherwise
  // wrap when narrowed to the shifter width, so saturate first.
  function automatic logic [31:0] clamp_shift(input logic [31:0] diff,
                                              input logic [31:0] limit);
    return (diff > limit) ? limit : diff;
  endfunction

endpackage

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - control sequencer for the multi-cycle floating-point adder
//
// Purpose: accepts an operand pair, steers alignment, normalisation (right, left
// or none), one optional rounding renormalise and the special/overflow bypass,
// then holds the result until the consumer takes it.
// Ports:
//   Clock, Reset                      clock, synchronous active-high reset
//   InValid/InReady                   operand handshake (ready only in IDLE)
//   Special, ExpSet, ExpDiff          classifier / exponent-difference inputs
//   FFOValid, FFOIndex                leading-one detector of the sum
//   RoundCarry, ExpMax                rounding carry, exponent about to overflow
//   SelExpMux, SelSRMuxL, SelSRMuxG,
//   ShiftRightEnable, ShiftRightAmount   alignment steering
//   SREn, SLEn, NoShift, IncrEn,
//   DecrEn, ShiftAmount               normalise steering
//   SelExpMuxR, SelManMuxR            select rounded exponent/mantissa
//   SelSpecial                        load special/overflow value
//   OutValid/OutReady                 result handshake
//   Overflow                          registered overflow-to-infinity flag

module fp_add_sequencer
  import fp_ctrl_pkg::*;
#(
  parameter int EXPBITS      = 8,
  parameter int MANTISSABITS = 23
) (
  input  logic                                  Clock,
  input  logic                                  Reset,
  input  logic                                  InValid,
  output logic                                  InReady,
  input  logic                                  Special,
  input  logic                                  ExpSet,
  input  logic [EXPBITS-1:0]                    ExpDiff,
  input  logic                                  FFOValid,
  input  logic [$clog2(MANTISSABITS+2)-1:0]     FFOIndex,
  input  logic                                  RoundCarry,
  input  logic                                  ExpMax,
  output logic                                  SelExpMux,
  output logic                                  SelSRMuxL,
  output logic                                  SelSRMuxG,
  output logic                                  ShiftRightEnable,
  output logic [$clog2(MANTISSABITS+2)-1:0]     ShiftRightAmount,
  output logic                                  SREn,
  output logic                                  SLEn,
  output logic                                  NoShift,
  output logic                                  IncrEn,
  output logic                                  DecrEn,
  output logic [$clog2(MANTISSABITS+2)-1:0]     ShiftAmount,
  output logic                                  SelExpMuxR,
  output logic                                  SelManMuxR,
  output logic                                  SelSpecial,
  output logic                                  OutValid,
  input  logic                                  OutReady,
  output logic                                  Overflow
);

  localparam int IDXBITS = $clog2(MANTISSABITS + 2);
  localparam logic [IDXBITS-1:0] CARRY = IDXBITS'(MANTISSABITS + 1);
  localparam logic [IDXBITS-1:0] ONE   = IDXBITS'(MANTISSABITS);

  SeqState state_q, state_d;
  SeqState align_exit;
  logic    overflow_q, overflow_d;
  logic [IDXBITS-1:0] sr_amount;

  assign sr_amount = IDXBITS'(clamp_shift(32'(ExpDiff), 32'(MANTISSABITS + 1)));
  assign Overflow  = overflow_q;

  // Leaving alignment: no leading one means a zero sum, which needs no shift.
  // An index above the carry position cannot occur; treat it as no shift.
  always_comb begin
    align_exit = NOSHIFT;
    if (FFOValid) begin
      if (FFOIndex == CARRY) begin
        align_exit = SR;
      end else if (FFOIndex < ONE) begin
        align_exit = SL;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    overflow_d       = overflow_q;
    InReady          = 1'b0;
    OutValid         = 1'b0;
    SelExpMux        = 1'b0;
    SelSRMuxL        = 1'b0;
    SelSRMuxG        = 1'b0;
    ShiftRightEnable = 1'b0;
    ShiftRightAmount = '0;
    SREn             = 1'b0;
    SLEn             = 1'b0;
    NoShift          = 1'b0;
    IncrEn           = 1'b0;
    DecrEn           = 1'b0;
    ShiftAmount      = '0;
    SelExpMuxR       = 1'b0;
    SelManMuxR       = 1'b0;
    SelSpecial       = 1'b0;
    // Under reset every output is forced low so no partial result leaks out.
    if (!Reset) begin
      case (state_q)
        IDLE: begin
          InReady = 1'b1;
          if (InValid) begin
            overflow_d = 1'b0;
            if (Special) begin
              state_d = SPECIAL;
            end else if (ExpDiff == '0) begin
              state_d = ALIGN_EQ;
            end else if (ExpSet) begin
              state_d = ALIGN_GT;
            end else begin
              state_d = ALIGN_LT;
            end
          end
        end
        ALIGN_EQ: begin
          SelExpMux        = 1'b1;
          SelSRMuxG        = 1'b1;
          ShiftRightAmount = sr_amount;
          state_d          = align_exit;
        end
        ALIGN_GT: begin
          SelExpMux        = 1'b1;
          SelSRMuxG        = 1'b1;
          ShiftRightEnable = 1'b1;
          ShiftRightAmount = sr_amount;
          state_d          = align_exit;
        end
        ALIGN_LT: begin
          SelSRMuxL        = 1'b1;
          ShiftRightEnable = 1'b1;
          ShiftRightAmount = sr_amount;
          state_d          = align_exit;
        end
        SR: begin
          SREn   = 1'b1;
          IncrEn = 1'b1;
          // A carry-out normalise on a saturated exponent goes straight to infinity.
          if (ExpMax) begin
            state_d    = SPECIAL;
            overflow_d = 1'b1;
          end else begin
            state_d = RoundCarry ? ROUND : RESULT;
          end
        end
        SL: begin
          SLEn        = 1'b1;
          DecrEn      = 1'b1;
          ShiftAmount = ONE - FFOIndex;
          state_d     = RoundCarry ? ROUND : RESULT;
        end
        NOSHIFT: begin
          NoShift = 1'b1;
          state_d = RoundCarry ? ROUND : RESULT;
        end
        ROUND: begin
          // Single renormalise after rounding; never loops back.
          SelExpMuxR = 1'b1;
          SelManMuxR = 1'b1;
          SREn       = 1'b1;
          IncrEn     = 1'b1;
          if (ExpMax) begin
            state_d    = SPECIAL;
            overflow_d = 1'b1;
          end else begin
            state_d = RESULT;
          end
        end
        SPECIAL: begin
          SelSpecial = 1'b1;
          state_d    = RESULT;
        end
        RESULT: begin
          OutValid = 1'b1;
          if (OutReady) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - scoreboard bench for fp_add_sequencer

module tb_fp_add_sequencer;

  localparam int EXPBITS      = 8;
  localparam int MANTISSABITS = 23;
  localparam int IDXBITS      = 5;
  localparam int CARRY        = 24;
  localparam int ONE          = 23;

  logic Clock = 1'b0;
  logic Reset;
  logic InValid, InReady, Special, ExpSet;
  logic [EXPBITS-1:0] ExpDiff;
  logic FFOValid;
  logic [IDXBITS-1:0] FFOIndex;
  logic RoundCarry, ExpMax;
  logic SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable;
  logic [IDXBITS-1:0] ShiftRightAmount;
  logic SREn, SLEn, NoShift, IncrEn, DecrEn;
  logic [IDXBITS-1:0] ShiftAmount;
  logic SelExpMuxR, SelManMuxR, SelSpecial;
  logic OutValid, OutReady, Overflow;

  always #5 Clock = ~Clock;

  fp_add_sequencer #(.EXPBITS(EXPBITS), .MANTISSABITS(MANTISSABITS)) dut (
    .Clock(Clock), .Reset(Reset),
    .InValid(InValid), .InReady(InReady),
    .Special(Special), .ExpSet(ExpSet), .ExpDiff(ExpDiff),
    .FFOValid(FFOValid), .FFOIndex(FFOIndex),
    .RoundCarry(RoundCarry), .ExpMax(ExpMax),
    .SelExpMux(SelExpMux), .SelSRMuxL(SelSRMuxL), .SelSRMuxG(SelSRMuxG),
    .ShiftRightEnable(ShiftRightEnable), .ShiftRightAmount(ShiftRightAmount),
    .SREn(SREn), .SLEn(SLEn), .NoShift(NoShift), .IncrEn(IncrEn), .DecrEn(DecrEn),
    .ShiftAmount(ShiftAmount),
    .SelExpMuxR(SelExpMuxR), .SelManMuxR(SelManMuxR), .SelSpecial(SelSpecial),
    .OutValid(OutValid), .OutReady(OutReady), .Overflow(Overflow)
  );

  typedef struct {
    bit special;
    bit exp_set;
    int diff;
    bit ffo_valid;
    int ffo_index;
    bit round_carry;
    bit exp_max;
  } stim_t;

  typedef struct {
    int lat;
    bit ovf;
  } txn_t;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [21:0] exp_step_q[$];
  txn_t        exp_txn_q[$];

  function automatic logic [21:0] steer(
      input logic sem, input logic ssl, input logic ssg, input logic sre,
      input logic [4:0] sra,
      input logic sr, input logic sl, input logic ns, input logic inc, input logic dec,
      input logic [4:0] sa,
      input logic ser, input logic smr, input logic ssp);
    return {sem, ssl, ssg, sre, sra, sr, sl, ns, inc, dec, sa, ser, smr, ssp};
  endfunction

  logic [21:0] obs;
  assign obs = steer(SelExpMux, SelSRMuxL, SelSRMuxG, ShiftRightEnable, ShiftRightAmount,
                     SREn, SLEn, NoShift, IncrEn, DecrEn, ShiftAmount,
                     SelExpMuxR, SelManMuxR, SelSpecial);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: walk the operation phase by phase from the rules and
  // record what the steering bus must show each cycle, plus latency/overflow.
  task automatic predict(input stim_t s);
    txn_t t;
    int amt;
    bit right;
    t.ovf = 1'b0;
    if (s.special) begin
      exp_step_q.push_back(steer(0,0,0,0,5'd0, 0,0,0,0,0,5'd0, 0,0,1));
      t.lat = 2;
    end else begin
      amt = (s.diff > CARRY) ? CARRY : s.diff;
      if (s.diff == 0)
        exp_step_q.push_back(steer(1,0,1,0,5'(amt), 0,0,0,0,0,5'd0, 0,0,0));
      else if (s.exp_set)
        exp_step_q.push_back(steer(1,0,1,1,5'(amt), 0,0,0,0,0,5'd0, 0,0,0));
      else
        exp_step_q.push_back(steer(0,1,0,1,5'(amt), 0,0,0,0,0,5'd0, 0,0,0));
      right = 1'b0;
      if (s.ffo_valid && s.ffo_index == CARRY) begin
        right = 1'b1;
        exp_step_q.push_back(steer(0,0,0,0,5'd0, 1,0,0,1,0,5'd0, 0,0,0));
      end else if (s.ffo_valid && s.ffo_index < ONE) begin
        exp_step_q.push_back(steer(0,0,0,0,5'd0, 0,1,0,0,1,5'(ONE - s.ffo_index), 0,0,0));
      end else begin
        exp_step_q.push_back(steer(0,0,0,0,5'd0, 0,0,1,0,0,5'd0, 0,0,0));
      end
      t.lat = 3;
      if (right && s.exp_max) begin
        exp_step_q.push_back(steer(0,0,0,0,5'd0, 0,0,0,0,0,5'd0, 0,0,1));
        t.lat = 4;
        t.ovf = 1'b1;
      end else if (s.round_carry) begin
        exp_step_q.push_back(steer(0,0,0,0,5'd0, 1,0,0,1,0,5'd0, 1,1,0));
        t.lat = 4;
        if (s.exp_max) begin
          exp_step_q.push_back(steer(0,0,0,0,5'd0, 0,0,0,0,0,5'd0, 0,0,1));
          t.lat = 5;
          t.ovf = 1'b1;
        end
      end
    end
    exp_txn_q.push_back(t);
  endtask

  // Monitor: tracks each operation from accept to result handshake and compares
  // per-cycle steering, latency and the overflow flag against the scoreboard.
  initial begin
    bit busy = 1'b0;
    bit seen = 1'b0;
    int cnt = 0;
    txn_t t;
    forever begin
      @(negedge Clock);
      if (!mon_en || Reset) begin
        busy = 1'b0;
        seen = 1'b0;
      end else if (!busy) begin
        check("idle_steer", 32'(obs), 32'd0);
        check("idle_ready", 32'(InReady), 32'd1);
        check("idle_outvalid", 32'(OutValid), 32'd0);
        if (InValid && InReady) begin
          busy = 1'b1;
          seen = 1'b0;
          cnt  = 0;
        end
      end else begin
        cnt++;
        if (!OutValid) begin
          check("busy_ready", 32'(InReady), 32'd0);
          if (exp_step_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL step_extra actual=%0h required=none cycle=%0d", obs, cnt);
          end else begin
            check("step", 32'(obs), 32'(exp_step_q.pop_front()));
          end
          if (cnt > 8) begin
            total++;
            bad++;
            $display("FAIL result_timeout actual=%0d required<=5", cnt);
            busy = 1'b0;
          end
        end else begin
          if (!seen) begin
            seen = 1'b1;
            if (exp_txn_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL txn_extra actual=result required=none");
            end else begin
              t = exp_txn_q.pop_front();
              check("latency", 32'(cnt), 32'(t.lat));
              check("overflow", 32'(Overflow), 32'(t.ovf));
            end
          end
          check("held_steer", 32'(obs), 32'd0);
          check("held_ready", 32'(InReady), 32'd0);
          if (OutReady) begin
            busy = 1'b0;
            seen = 1'b0;
          end
        end
      end
    end
  end

  task automatic apply(input stim_t s);
    Special    = s.special;
    ExpSet     = s.exp_set;
    ExpDiff    = 8'(s.diff);
    FFOValid   = s.ffo_valid;
    FFOIndex   = 5'(s.ffo_index);
    RoundCarry = s.round_carry;
    ExpMax     = s.exp_max;
  endtask

  // Driver: called at posedge+1; inputs stay stable for the whole operation.
  task automatic run_txn(input stim_t s, input int hold);
    bit ok;
    apply(s);
    predict(s);
    InValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (InReady) begin
        ok = 1'b1;
        @(posedge Clock); #1;
        break;
      end
      @(posedge Clock); #1;
    end
    InValid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout actual=no_accept required=accept");
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (OutValid) begin
        ok = 1'b1;
        break;
      end
      @(posedge Clock); #1;
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL outvalid_timeout actual=0 required=1");
    end
    repeat (hold) begin
      @(posedge Clock); #1;
    end
    OutReady = 1'b1;
    @(posedge Clock); #1;
    OutReady = 1'b0;
  endtask

  function automatic stim_t mk(input bit sp, input bit es, input int d, input bit fv,
                               input int fi, input bit rc, input bit em);
    stim_t s;
    s.special = sp; s.exp_set = es; s.diff = d; s.ffo_valid = fv;
    s.ffo_index = fi; s.round_carry = rc; s.exp_max = em;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int r;
    s.special = ($urandom_range(0, 7) == 0);
    s.exp_set = $urandom_range(0, 1) == 1;
    r = $urandom_range(0, 3);
    case (r)
      0: s.diff = 0;
      1: s.diff = $urandom_range(1, 24);
      2: s.diff = $urandom_range(25, 255);
      default: s.diff = $urandom_range(1, 30);
    endcase
    s.ffo_valid   = ($urandom_range(0, 7) != 0);
    s.ffo_index   = $urandom_range(0, 31);
    s.round_carry = ($urandom_range(0, 2) == 0);
    s.exp_max     = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  initial begin
    bit ok;
    Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge Clock);
    check("reset_inready", 32'(InReady), 32'd0);
    check("reset_outvalid", 32'(OutValid), 32'd0);
    check("reset_steer", 32'(obs), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    check("post_reset_overflow", 32'(Overflow), 32'd0);
    check("post_reset_inready", 32'(InReady), 32'd1);
    @(posedge Clock); #1;
    mon_en = 1'b1;

    run_txn(mk(0, 0, 0, 1, 23, 0, 0), 0);   // equal exponents, no shift
    run_txn(mk(0, 1, 40, 1, 23, 0, 0), 0);  // clamp to 24
    run_txn(mk(0, 0, 5, 1, 23, 0, 0), 0);   // B larger, amount 5
    run_txn(mk(0, 1, 3, 1, 20, 0, 0), 0);   // left shift by 3
    run_txn(mk(0, 1, 3, 0, 20, 0, 0), 0);   // zero sum
    run_txn(mk(0, 1, 2, 1, 24, 1, 0), 0);   // right shift then round
    run_txn(mk(0, 1, 2, 1, 24, 0, 1), 0);   // overflow from SR
    run_txn(mk(1, 0, 9, 1, 24, 1, 1), 0);   // special bypass
    run_txn(mk(0, 0, 1, 1, 30, 1, 1), 0);   // illegal index, round overflow
    run_txn(mk(0, 1, 24, 1, 0, 0, 0), 5);   // consumer stalls 5 cycles
    run_txn(mk(0, 1, 25, 1, 22, 1, 0), 1);

    for (int n = 0; n < 300; n++) begin
      run_txn(rand_stim(), $urandom_range(0, 3));
    end

    // Reset while left-normalising aborts the operation.
    mon_en = 1'b0;
    apply(mk(0, 1, 3, 1, 20, 0, 0));
    InValid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clock); #1;
      InValid = 1'b0;
      if (SLEn) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort_reached_sl", 32'(ok), 32'd1);
    check("abort_sl_amount", 32'(ShiftAmount), 32'd3);
    Reset = 1'b1;
    @(negedge Clock);
    check("abort_reset_inready", 32'(InReady), 32'd0);
    check("abort_reset_outvalid", 32'(OutValid), 32'd0);
    check("abort_reset_steer", 32'(obs), 32'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("abort_idle_outvalid", 32'(OutValid), 32'd0);
      check("abort_idle_steer", 32'(obs), 32'd0);
      check("abort_idle_inready", 32'(InReady), 32'd1);
    end
    check("pending_steps", 32'(exp_step_q.size()), 32'd0);
    check("pending_txns", 32'(exp_txn_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
